autoconfig_sequencer: RTL and testbench
=======================================

Name: autoconfig_sequencer

Overview:
- Owns the 512x4 autoconfig nibble ROM/RAM and runs the Amiga autoconfig chain (Z2 at $E80000, Z3 at $FF000000) for up to 7 board slots; slot 7 is the all-ones null board.
- After reset or reconfig, patches the size nibbles from the platform memory configuration.
- During chain operation it exposes the lowest enabled, unconfigured slot. It latches base addresses and shut-up writes and publishes per-slot config-done flags and base addresses to the address decoders.

Parameters:
SLOT_Z3, 7'b0011110, bit n=1 means slot n is a Zorro III board (base written at $44); otherwise Zorro II (base at $4A then $48)
NSLOT, 7, number of real board slots; each slot is a 64-nibble window at ROM index slot*64

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
reconfig  in  1  one-cycle pulse: clear all config state and re-run patching (CPU reset)
board_en  in  7  per-slot enable; disabled slots are skipped in the chain
z2_size  in  4  nibble patched into slot0 reg $02
z3_size  in  4  nibble patched into slot1 reg $02
bank0_size  in  4  nibble patched into slot3 reg $0A
cfg_rd  in  1  read request, held until cfg_ack
cfg_wr  in  1  write request, held until cfg_ack
cfg_addr  in  6  register byte offset bits [6:1] within autoconfig space
cfg_din  in  16  write data (Z2 nibble in [15:12]; Z3 $44 word = A31..A16)
cfg_dout  out  16  read data, ROM nibble in [15:12], [11:0]=all ones
cfg_ack  out  1  one-cycle completion strobe
ready  out  1  patching finished; chain accepts requests
cfg_done  out  7  per-slot configured-or-shut-up flag
shutup  out  7  per-slot shut-up flag
base_addr  out  112  slot n base in [16n+15:16n] as A31..A16 (Z2: upper byte 0)
rom_a_read  out  9  ROM read index
rom_a_write  out  9  ROM write index
rom_d  out  4  ROM write data
rom_we  out  1  ROM write enable

Behaviour:
- Reset (async) or reconfig:
  - cfg_done, shutup, base_addr, z2 pending-low nibble, cfg_ack, rom_we and ready all 0.
  - cfg_dout = 16'hFFFF; rom_a_read = 9'h1C0.
  - State goes to PATCH0. Reconfig mid-operation aborts any request without cfg_ack.
- Patching:
  - PATCH0/1/2 write one nibble per cycle (rom_we=1): {0,$01}=z2_size, {64,$01}=z3_size, {192,$05}=bank0_size.
  - Then IDLE with ready=1 (registered, asserted the cycle after PATCH2).
- cur_slot (combinational): lowest n with board_en[n] && !cfg_done[n]. If there is none, cur_slot=7, which reads all ones (null board, ends the chain).
- IDLE arbitration: requests are sampled only in IDLE with ready=1. If cfg_wr and cfg_rd are both high, the write wins.
- Read:
  - Edge N samples cfg_rd; rom_a_read <= {cur_slot, cfg_addr}.
  - The ROM read latency is 2 (address registered, then data registered), so rom_q is valid after edge N+2.
  - At edge N+3: cfg_dout <= {q, 12'hFFF} and cfg_ack=1 for one cycle. State returns to IDLE at edge N+4. States: RD1, RD2, RD3.
  - cur_slot is frozen at sampling.
- Write (ack one cycle after sampling, state WACK), decoded on cfg_addr*2:
  - Z2 slot, $4A: pending_lo <= din[15:12].
  - Z2 slot, $48: base <= {8'h00, din[15:12], pending_lo}; cfg_done set.
  - Z3 slot, $44: base <= din[15:0]; cfg_done set.
  - $4C, any slot: shutup and cfg_done set; base = 0.
  - All other offsets, Z3 $48/$4A, Z2 $44, and any write with cur_slot=7: no effect, still acked.
- cfg_done/base updates are visible on the edge that asserts cfg_ack. The next request therefore sees the next slot.
- Changing board_en while not configured only changes cur_slot; already-configured slots keep their flags.
- rom_we is asserted only in PATCH states. The requester must drop cfg_rd/cfg_wr in the cycle after cfg_ack to avoid a repeat.

Decomposition:
- Shared package autoconfig_pkg: slot index constants (Z2RAM=0, Z3RAM=1, Z3RAM2=2, Z3BANK0=3, ETH=4, SND=5, CTRL=6, NULL=7), register offsets ($02,$0A,$44,$48,$4A,$4C), the state enum and the patch-table entries.
- The existing Autoconfig_ROM is instantiated by the parent, not inside this block.
- One natural sub-module: autoconfig_slot_select, a priority encoder from board_en & ~cfg_done to cur_slot.

Test Plan:
- Reset release with z2_size=4'h7, z3_size=4'h0, bank0_size=4'h8 -> rom_we for exactly 3 cycles at indices 9'h001, 9'h041, 9'h0C5 with those data; ready=1 the next cycle.
- board_en=7'h01, cfg_rd at offset $00 -> cfg_ack exactly 3 cycles later with cfg_dout=16'hEFFF.
- Z2 chain: write $4A din=16'h0000, then $48 din=16'h2000 -> base_addr[15:0]=16'h0020, cfg_done=7'h01. A following read of $00 returns slot 7 (16'hFFFF).
- board_en=7'h16 -> first read targets slot1. Write $44 din=16'h4000 -> base slot1=16'h4000; next read index 9'h080; write $4C -> shutup[2]=1; next slot is 4.
- cfg_rd and cfg_wr high together at $4C -> treated as a write (shutup set), single ack.
- reconfig pulsed at RD2 -> no cfg_ack; cfg_done=0, base_addr=0; the patch writes repeat.

Source files
------------

// File: rtl/autoconfig_pkg.sv
// Shared constants for the autoconfig sequencer: slot numbers, register
// offsets, sequencer state codes and the size-nibble patch table.
package autoconfig_pkg;

  localparam logic [2:0] SLOT_Z2RAM   = 3'd0;
  localparam logic [2:0] SLOT_Z3RAM   = 3'd1;
  localparam logic [2:0] SLOT_Z3RAM2  = 3'd2;
  localparam logic [2:0] SLOT_Z3BANK0 = 3'd3;
  localparam logic [2:0] SLOT_ETH     = 3'd4;
  localparam logic [2:0] SLOT_SND     = 3'd5;
  localparam logic [2:0] SLOT_CTRL    = 3'd6;
  localparam logic [2:0] SLOT_NULL    = 3'd7;

  localparam logic [6:0] REG_SIZE       = 7'h02;
  localparam logic [6:0] REG_BANK_SIZE  = 7'h0A;
  localparam logic [6:0] REG_Z3_BASE    = 7'h44;
  localparam logic [6:0] REG_Z2_BASE_HI = 7'h48;
  localparam logic [6:0] REG_Z2_BASE_LO = 7'h4A;
  localparam logic [6:0] REG_SHUTUP     = 7'h4C;

  localparam logic [3:0] ST_PATCH0 = 4'd0;
  localparam logic [3:0] ST_PATCH1 = 4'd1;
  localparam logic [3:0] ST_PATCH2 = 4'd2;
  localparam logic [3:0] ST_IDLE   = 4'd3;
  localparam logic [3:0] ST_RD1    = 4'd4;
  localparam logic [3:0] ST_RD2    = 4'd5;
  localparam logic [3:0] ST_RD3    = 4'd6;
  localparam logic [3:0] ST_WACK   = 4'd7;
  localparam logic [3:0] ST_HOLD   = 4'd8;

  // ROM index = {slot, byte offset [6:1]}
  localparam logic [8:0] PATCH_Z2_IDX    = {SLOT_Z2RAM,   REG_SIZE[6:1]};
  localparam logic [8:0] PATCH_Z3_IDX    = {SLOT_Z3RAM,   REG_SIZE[6:1]};
  localparam logic [8:0] PATCH_BANK0_IDX = {SLOT_Z3BANK0, REG_BANK_SIZE[6:1]};

endpackage

// File: rtl/autoconfig_slot_select.sv
// Priority encoder: lowest available slot, or the null slot when none is left.
module autoconfig_slot_select
  import autoconfig_pkg::*;
#(
  parameter int NSLOT = 7
) (
  input  logic [NSLOT-1:0] avail,
  output logic [2:0]       cur_slot
);

  always_comb begin
    cur_slot = SLOT_NULL;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (avail[i]) cur_slot = i[2:0];
    end
  end

endmodule

// File: rtl/autoconfig_sequencer.sv
// Autoconfig chain sequencer: patches size nibbles into the external nibble
// ROM, then serves reads/writes for the lowest enabled unconfigured slot.
module autoconfig_sequencer
  import autoconfig_pkg::*;
#(
  parameter logic [6:0] SLOT_Z3 = 7'b0011110,
  parameter int         NSLOT   = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reconfig,
  input  logic [NSLOT-1:0]      board_en,
  input  logic [3:0]            z2_size,
  input  logic [3:0]            z3_size,
  input  logic [3:0]            bank0_size,
  input  logic                  cfg_rd,
  input  logic                  cfg_wr,
  input  logic [5:0]            cfg_addr,
  input  logic [15:0]           cfg_din,
  output logic [15:0]           cfg_dout,
  output logic                  cfg_ack,
  output logic                  ready,
  output logic [NSLOT-1:0]      cfg_done,
  output logic [NSLOT-1:0]      shutup,
  output logic [16*NSLOT-1:0]   base_addr,
  output logic [8:0]            rom_a_read,
  output logic [8:0]            rom_a_write,
  output logic [3:0]            rom_d,
  output logic                  rom_we,
  input  logic [3:0]            rom_q
);

  logic [3:0]  state;
  logic [2:0]  cur_slot;
  logic [2:0]  req_slot;
  logic [5:0]  req_addr;
  logic [15:0] req_din;
  logic [3:0]  pending_lo;
  logic [6:0]  req_off;

  assign req_off = {req_addr, 1'b0};

  autoconfig_slot_select #(.NSLOT(NSLOT)) u_slot_select (
    .avail    (board_en & ~cfg_done),
    .cur_slot (cur_slot)
  );

  // Reconfig behaves exactly like reset but is sampled synchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_PATCH0;
      cfg_done    <= '0;
      shutup      <= '0;
      base_addr   <= '0;
      pending_lo  <= '0;
      cfg_ack     <= 1'b0;
      cfg_dout    <= 16'hFFFF;
      ready       <= 1'b0;
      rom_we      <= 1'b0;
      rom_a_read  <= 9'h1C0;
      rom_a_write <= '0;
      rom_d       <= '0;
      req_slot    <= SLOT_NULL;
      req_addr    <= '0;
      req_din     <= '0;
    end else if (reconfig) begin
      state       <= ST_PATCH0;
      cfg_done    <= '0;
      shutup      <= '0;
      base_addr   <= '0;
      pending_lo  <= '0;
      cfg_ack     <= 1'b0;
      cfg_dout    <= 16'hFFFF;
      ready       <= 1'b0;
      rom_we      <= 1'b0;
      rom_a_read  <= 9'h1C0;
      rom_a_write <= '0;
      rom_d       <= '0;
      req_slot    <= SLOT_NULL;
      req_addr    <= '0;
      req_din     <= '0;
    end else begin
      cfg_ack <= 1'b0;
      rom_we  <= 1'b0;
      case (state)
        ST_PATCH0: begin
          rom_we      <= 1'b1;
          rom_a_write <= PATCH_Z2_IDX;
          rom_d       <= z2_size;
          state       <= ST_PATCH1;
        end
        ST_PATCH1: begin
          rom_we      <= 1'b1;
          rom_a_write <= PATCH_Z3_IDX;
          rom_d       <= z3_size;
          state       <= ST_PATCH2;
        end
        ST_PATCH2: begin
          rom_we      <= 1'b1;
          rom_a_write <= PATCH_BANK0_IDX;
          rom_d       <= bank0_size;
          state       <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!ready) begin
            ready <= 1'b1;
          end else if (cfg_wr) begin
            req_slot <= cur_slot;
            req_addr <= cfg_addr;
            req_din  <= cfg_din;
            state    <= ST_WACK;
          end else if (cfg_rd) begin
            rom_a_read <= {cur_slot, cfg_addr};
            state      <= ST_RD1;
          end
        end
        ST_RD1: state <= ST_RD2;
        ST_RD2: state <= ST_RD3;
        ST_RD3: begin
          cfg_dout <= {rom_q, 12'hFFF};
          cfg_ack  <= 1'b1;
          state    <= ST_HOLD;
        end
        ST_WACK: begin
          cfg_ack <= 1'b1;
          state   <= ST_HOLD;
          if (req_slot != SLOT_NULL) begin
            if (req_off == REG_SHUTUP) begin
              shutup[req_slot]                    <= 1'b1;
              cfg_done[req_slot]                  <= 1'b1;
              base_addr[{req_slot, 4'b0000} +: 16] <= 16'h0000;
            end else if (SLOT_Z3[req_slot]) begin
              if (req_off == REG_Z3_BASE) begin
                base_addr[{req_slot, 4'b0000} +: 16] <= req_din;
                cfg_done[req_slot]                  <= 1'b1;
              end
            end else if (req_off == REG_Z2_BASE_LO) begin
              pending_lo <= req_din[15:12];
            end else if (req_off == REG_Z2_BASE_HI) begin
              base_addr[{req_slot, 4'b0000} +: 16] <= {8'h00, req_din[15:12], pending_lo};
              cfg_done[req_slot]                  <= 1'b1;
            end
          end
        end
        // One dead cycle lets the requester drop its strobe before re-arbitration.
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_autoconfig_sequencer.sv
// Self-checking bench for autoconfig_sequencer with a nibble-ROM model and a
// transaction-level model of the autoconfig chain.
module tb_autoconfig_sequencer;

  localparam logic [6:0] Z3_MAP = 7'b0011110;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         reconfig = 1'b0;
  logic [6:0]   board_en = 7'h01;
  logic [3:0]   z2_size = 4'h7;
  logic [3:0]   z3_size = 4'h0;
  logic [3:0]   bank0_size = 4'h8;
  logic         cfg_rd = 1'b0;
  logic         cfg_wr = 1'b0;
  logic [5:0]   cfg_addr = '0;
  logic [15:0]  cfg_din = '0;
  logic [15:0]  cfg_dout;
  logic         cfg_ack;
  logic         ready;
  logic [6:0]   cfg_done;
  logic [6:0]   shutup;
  logic [111:0] base_addr;
  logic [8:0]   rom_a_read;
  logic [8:0]   rom_a_write;
  logic [3:0]   rom_d;
  logic         rom_we;
  logic [3:0]   rom_q;

  int errors = 0;
  int checks = 0;

  autoconfig_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .reconfig    (reconfig),
    .board_en    (board_en),
    .z2_size     (z2_size),
    .z3_size     (z3_size),
    .bank0_size  (bank0_size),
    .cfg_rd      (cfg_rd),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_din     (cfg_din),
    .cfg_dout    (cfg_dout),
    .cfg_ack     (cfg_ack),
    .ready       (ready),
    .cfg_done    (cfg_done),
    .shutup      (shutup),
    .base_addr   (base_addr),
    .rom_a_read  (rom_a_read),
    .rom_a_write (rom_a_write),
    .rom_d       (rom_d),
    .rom_we      (rom_we),
    .rom_q       (rom_q)
  );

  always #5 clk = ~clk;

  // Initial ROM image: slot 0 reg $00 reads E, the null slot reads all ones.
  function automatic logic [3:0] romInit(input int i);
    if (i >= 448) return 4'hF;
    return 4'((i * 5 + 14) % 16);
  endfunction

  // External ROM: write port plus registered address and registered data.
  logic [3:0] rom_mem [512];
  logic [8:0] ra_q;
  logic       rom_load = 1'b0;
  always @(posedge clk) begin
    if (rom_load) begin
      for (int i = 0; i < 512; i++) rom_mem[i] <= romInit(i);
    end else if (rom_we) begin
      rom_mem[rom_a_write] <= rom_d;
    end
    ra_q  <= rom_a_read;
    rom_q <= rom_mem[ra_q];
  end

  // Chain model
  logic [6:0]  exp_done = '0;
  logic [6:0]  exp_shutup = '0;
  logic [15:0] exp_base [7];
  logic [3:0]  exp_pending = '0;
  logic        busy = 1'b1;
  logic        checking = 1'b0;

  function automatic logic [2:0] mdlCurSlot();
    for (int i = 0; i < 7; i++) begin
      if (board_en[i] && !exp_done[i]) return 3'(i);
    end
    return 3'd7;
  endfunction

  function automatic logic [15:0] modelRead(input logic [2:0] slot, input logic [5:0] addr);
    int idx;
    logic [3:0] nib;
    idx = int'(slot) * 64 + int'(addr);
    if (slot == 3'd7)    nib = 4'hF;
    else if (idx == 1)   nib = z2_size;
    else if (idx == 65)  nib = z3_size;
    else if (idx == 197) nib = bank0_size;
    else                 nib = romInit(idx);
    return {nib, 12'hFFF};
  endfunction

  task automatic modelWrite(input logic [2:0] slot, input logic [5:0] addr, input logic [15:0] din);
    int off;
    off = int'(addr) * 2;
    if (slot == 3'd7) return;
    if (off == 'h4C) begin
      exp_shutup[slot] = 1'b1;
      exp_done[slot]   = 1'b1;
      exp_base[slot]   = 16'h0000;
    end else if (Z3_MAP[slot]) begin
      if (off == 'h44) begin
        exp_base[slot] = din;
        exp_done[slot] = 1'b1;
      end
    end else if (off == 'h4A) begin
      exp_pending = din[15:12];
    end else if (off == 'h48) begin
      exp_base[slot] = {8'h00, din[15:12], exp_pending};
      exp_done[slot] = 1'b1;
    end
  endtask

  task automatic modelReset();
    exp_done = '0;
    exp_shutup = '0;
    exp_pending = '0;
    for (int i = 0; i < 7; i++) exp_base[i] = '0;
  endtask

  function automatic logic [111:0] packBase();
    logic [111:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[i*16 +: 16] = exp_base[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Continuous comparison of the published config state while idle.
  always @(negedge clk) begin
    if (checking && !busy) begin
      checkOutput("cyc_cfg_done", cfg_done, exp_done);
      checkOutput("cyc_shutup", shutup, exp_shutup);
      checkOutput("cyc_base_addr", base_addr, packBase());
      checkOutput("cyc_ready", ready, 1'b1);
      checkOutput("cyc_no_ack", cfg_ack, 1'b0);
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [5:0] addr,
                               input logic [15:0] din, output logic [15:0] dout);
    logic [2:0] slot;
    int cyc;
    int acks;
    logic got;
    slot = mdlCurSlot();
    busy = 1'b1;
    cfg_rd = rd;
    cfg_wr = wr;
    cfg_addr = addr;
    cfg_din = din;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (cfg_ack) got = 1'b1;
    end
    cfg_rd = 1'b0;
    cfg_wr = 1'b0;
    checkOutput("ack_seen", got, 1'b1);
    dout = cfg_dout;
    if (wr) modelWrite(slot, addr, din);
    else checkOutput("rd_data", cfg_dout, modelRead(slot, addr));
    checkOutput("ack_latency", cyc - 1, wr ? 1 : 3);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cfg_ack) acks++;
    end
    checkOutput("single_ack", acks, 0);
    busy = 1'b0;
  endtask

  task automatic checkPatch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [8:0] idx [3];
    logic [3:0] dat [3];
    int k, last, rdy, acks;
    idx[0] = 9'h001; idx[1] = 9'h041; idx[2] = 9'h0C5;
    dat[0] = a;      dat[1] = b;      dat[2] = c;
    k = 0; last = -10; rdy = -1; acks = 0;
    for (int cy = 0; cy < 10; cy++) begin
      @(negedge clk);
      if (cfg_ack) acks++;
      if (rom_we) begin
        if (k < 3) begin
          checkOutput("patch_idx", rom_a_write, idx[k]);
          checkOutput("patch_data", rom_d, dat[k]);
        end
        k++;
        last = cy;
      end
      if (ready && rdy < 0) rdy = cy;
    end
    checkOutput("patch_count", k, 3);
    checkOutput("ready_timing", rdy, last + 1);
    checkOutput("patch_no_ack", acks, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] d;
    modelReset();
    #1 reset_n = 1'b0;
    rom_load = 1'b1;
    repeat (2) @(negedge clk);
    rom_load = 1'b0;
    @(negedge clk);
    checkOutput("rst_dout", cfg_dout, 16'hFFFF);
    checkOutput("rst_rom_a_read", rom_a_read, 9'h1C0);
    checkOutput("rst_ack", cfg_ack, 1'b0);
    checkOutput("rst_we", rom_we, 1'b0);
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_done", cfg_done, 7'h00);
    checkOutput("rst_base", base_addr, 112'h0);
    reset_n = 1'b1;
    checkPatch(4'h7, 4'h0, 4'h8);
    busy = 1'b0;
    checking = 1'b1;

    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0, d);
    checkOutput("slot0_reg00_lit", d, 16'hEFFF);
    applyStimulus(1'b1, 1'b0, 6'h01, 16'h0, d);
    checkOutput("slot0_size_lit", d, 16'h7FFF);

    applyStimulus(1'b0, 1'b1, 6'h25, 16'h0000, d);
    applyStimulus(1'b0, 1'b1, 6'h24, 16'h2000, d);
    checkOutput("z2_base_lit", base_addr[15:0], 16'h0020);
    checkOutput("z2_done_lit", cfg_done, 7'h01);
    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0, d);
    checkOutput("null_read_lit", d, 16'hFFFF);

    board_en = 7'h16;
    applyStimulus(1'b1, 1'b0, 6'h01, 16'h0, d);
    checkOutput("slot1_index_lit", rom_a_read, 9'h041);
    checkOutput("slot1_size_lit", d, 16'h0FFF);
    applyStimulus(1'b0, 1'b1, 6'h22, 16'h4000, d);
    checkOutput("z3_base_lit", base_addr[31:16], 16'h4000);
    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0, d);
    checkOutput("slot2_index_lit", rom_a_read, 9'h080);
    applyStimulus(1'b0, 1'b1, 6'h26, 16'h0000, d);
    checkOutput("shutup2_lit", shutup, 7'h04);
    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0, d);
    checkOutput("slot4_index_lit", rom_a_read, 9'h100);
    applyStimulus(1'b1, 1'b1, 6'h26, 16'h0000, d);
    checkOutput("rdwr_shutup_lit", shutup, 7'h14);

    board_en = 7'h08;
    applyStimulus(1'b0, 1'b1, 6'h25, 16'hA000, d);
    applyStimulus(1'b0, 1'b1, 6'h24, 16'hB000, d);
    checkOutput("z3_ignores_z2_regs", cfg_done[3], 1'b0);
    applyStimulus(1'b0, 1'b1, 6'h22, 16'h1234, d);
    board_en = 7'h20;
    applyStimulus(1'b0, 1'b1, 6'h22, 16'h5555, d);
    applyStimulus(1'b0, 1'b1, 6'h25, 16'hF000, d);
    applyStimulus(1'b0, 1'b1, 6'h24, 16'h3000, d);
    checkOutput("slot5_base_lit", base_addr[95:80], 16'h003F);
    applyStimulus(1'b0, 1'b1, 6'h26, 16'h0000, d);
    applyStimulus(1'b1, 1'b0, 6'h00, 16'h0, d);
    checkOutput("chain_end_lit", d, 16'hFFFF);

    board_en = 7'h7F;
    z2_size = 4'h3;
    z3_size = 4'hC;
    bank0_size = 4'h5;
    busy = 1'b1;
    cfg_rd = 1'b1;
    cfg_addr = 6'h00;
    @(negedge clk);
    @(negedge clk);
    reconfig = 1'b1;
    cfg_rd = 1'b0;
    @(negedge clk);
    reconfig = 1'b0;
    checkOutput("rcfg_ack", cfg_ack, 1'b0);
    checkOutput("rcfg_done", cfg_done, 7'h00);
    checkOutput("rcfg_base", base_addr, 112'h0);
    checkOutput("rcfg_ready", ready, 1'b0);
    modelReset();
    checkPatch(4'h3, 4'hC, 4'h5);
    busy = 1'b0;

    board_en = 7'h01;
    applyStimulus(1'b1, 1'b0, 6'h01, 16'h0, d);
    checkOutput("repatched_size_lit", d, 16'h3FFF);
    board_en = 7'h08;
    applyStimulus(1'b1, 1'b0, 6'h05, 16'h0, d);
    checkOutput("repatched_bank_lit", d, 16'h5FFF);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
